// File: rtl/sync_fifo.sv
// sync_fifo: single-clock parametrised FIFO with standard or first-word-fall-through
// read mode, occupancy count, almost-full/almost-empty thresholds, synchronous
// flush and one-cycle overflow/underflow error pulses.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst_n        synchronous active-low reset (discards contents)
//   flush        synchronous clear of pointers/count/rd_valid (mem untouched)
//   wr_en/wr_data  push request and word
//   rd_en        pop request (FWFT: acknowledges the displayed word)
//   rd_data/rd_valid  read word and its qualifier
//   empty/full/almost_empty/almost_full  decoded from registered count
//   count        occupancy 0..DEPTH
//   overflow/underflow  registered one-cycle pulse per rejected request
module sync_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 64,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_acc, rd_acc;

    // Flags come only from the registered count, so a read in the same cycle
    // never frees a slot for a write while full (and vice versa when empty).
    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_C);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Flush wins over any request in the same cycle.
    assign wr_acc = wr_en && !full  && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = wr_en && full  && !flush;
        udf_d    = rd_en && empty && !flush;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is not reset; only pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) mem[wr_ptr_q] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always on the output; rd_en just pops it.
            assign rd_data  = mem[rd_ptr_q];
            assign rd_valid = !empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            // rd_data holds across idle and flush cycles; only rd_valid drops.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (rd_acc) begin
                    rd_data_q  <= mem[rd_ptr_q];
                    rd_valid_q <= 1'b1;
                end else begin
                    rd_valid_q <= 1'b0;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO for buffering bytes and words between same-clock producers and consumers in the bootloader and CPU datapath, such as the UART receive stage and the instruction loader. It extends the pointer-based FIFO used across clock domains with several additions:
- selectable standard or first-word-fall-through (FWFT) read mode;
- an occupancy count;
- programmable almost-full and almost-empty thresholds;
- a synchronous flush;
- overflow and underflow error pulses.

## Interface
- DATA_WIDTH, 8, width of each stored word
- DEPTH, 64, number of entries; must be a power of two, at least 2
- FWFT, 0, read mode: 0 = standard (registered output, one-cycle read latency), 1 = first-word-fall-through
- AFULL_THRESH, DEPTH-4, almost_full asserts when count >= this value; legal range 1..DEPTH
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this value; legal range 0..DEPTH-1

- clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of contents; does not clear mem
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read (pop) request
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  rd_data holds a valid word (meaning depends on mode)
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AEMPTY_THRESH
- almost_full  out  1  count >= AFULL_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
**State**
- wr_ptr, rd_ptr: $clog2(DEPTH) bits each; wrap modulo DEPTH.
- count register: $clog2(DEPTH)+1 bits.
- empty, full, almost_empty and almost_full are decoded combinationally from the count register only.

**Acceptance**
- Write accepted iff wr_en && !full. Writes mem[wr_ptr] and increments wr_ptr.
- Read accepted iff rd_en && !empty. Increments rd_ptr.
- A write while full is rejected even if a read is accepted in the same cycle. The flags come from registered count, so there is no same-cycle pass-through.

**Count update**
- Write only: +1. Read only: -1. Both or neither: unchanged.

**Errors**
- overflow = wr_en && full, registered, high for exactly one cycle per rejected request.
- underflow = rd_en && empty, registered, high for exactly one cycle per rejected request.
- Both are suppressed in flush cycles.

**Flush**
- Highest priority after reset.
- Sets wr_ptr = rd_ptr = count = 0 and rd_valid = 0.
- Any wr_en or rd_en in the same cycle is ignored.
- rd_data holds its value in standard mode.

**Standard mode (FWFT = 0)**
- On an accepted read, rd_data <= mem[rd_ptr] and rd_valid <= 1.
- Otherwise rd_valid <= 0 and rd_data holds its value.

**FWFT mode (FWFT = 1)**
- rd_data = mem[rd_ptr] combinationally.
- rd_valid = !empty.
- rd_en acknowledges and pops the displayed word.

## Timing
**Reset (rst_n = 0 at a rising edge)**
- Pointers and count go to 0; empty = 1, almost_empty = 1.
- full = 0, almost_full = 0 (AFULL_THRESH >= 1).
- rd_data = 0 in standard mode; rd_valid = 0; overflow = underflow = 0.
- Reset mid-operation discards all contents, exactly like a flush.

**Write latency**
- Write accepted at edge N: count, empty and the other flags reflect it after edge N, i.e. in cycle N+1.
- FWFT: the first word appears on rd_data with rd_valid = 1 in cycle N+1.
- Standard: rd_en asserted in cycle N+1 gives rd_data/rd_valid in cycle N+2.

**Read path**
- Standard mode: rd_en held high on a non-empty FIFO gives one word per cycle, each one cycle after its request.
- Fill to full then empty: pointers wrap cleanly; ordering is preserved across the wrap.

**Flag boundaries**
- count = DEPTH-1 plus a write: full in the next cycle.
- count = 1 plus a read: empty in the next cycle.

**Simultaneous read and write**
- At 0 < count < DEPTH: both accepted; count is constant.
- At count == 0: only the write is accepted; underflow pulses if rd_en was high.

## Test plan
- **Reset values:** pulse rst_n = 0 for one cycle. Expect count = 0, empty = 1, almost_empty = 1, full = 0, rd_valid = 0, rd_data = 0x00.
- **Fill and drain, standard mode (DEPTH = 8):** write 0x10..0x17 on consecutive cycles. Expect full one cycle after the 8th write. A 9th write gives overflow = 1 for one cycle and count stays 8. Then drain with rd_en held high: rd_data is 0x10..0x17 with rd_valid, each one cycle after its rd_en. A further rd_en gives underflow.
- **FWFT:** write 0xA5 at edge N. In cycle N+1 expect rd_data = 0xA5 and rd_valid = 1 with no rd_en. Assert rd_en: after the edge, empty = 1 and rd_valid = 0.
- **Simultaneous read/write and wrap (DEPTH = 8):** preload 3 words. Issue wr_en and rd_en together for 20 cycles with an incrementing pattern. Expect count = 3 throughout and output order identical to input order across pointer wrap.
- **Thresholds (AFULL_THRESH = 6, AEMPTY_THRESH = 2):** step count 0→8→0. almost_empty is high at counts 0..2 only; almost_full is high at counts 6..8 only. Each flag changes the cycle after the causing write or read.
- **Flush:** with count = 5, assert flush together with wr_en and rd_en. Next cycle: count = 0, empty = 1, rd_valid = 0, overflow = underflow = 0. A subsequent write of 0x3C is read back first.
